// File: rtl/test_s2p_if.sv
// Bundle of the two serial input channels and their parallel result outputs
// for the p2s loopback receiver.
interface test_s2p_if #(
    parameter int WIDTH24 = 24,
    parameter int WIDTH16 = 16,
    parameter int CNT_W   = 16
);
    logic               bit_en24;
    logic               sync24;
    logic               sdata24;
    logic               bit_en16;
    logic               sync16;
    logic               sdata16;
    logic [WIDTH24-1:0] pdata24;
    logic               pvalid24;
    logic               perr24;
    logic [WIDTH16-1:0] pdata16;
    logic               pvalid16;
    logic               perr16;
    logic [CNT_W-1:0]   wcnt24;
    logic [CNT_W-1:0]   wcnt16;

    modport master (
        output bit_en24, sync24, sdata24, bit_en16, sync16, sdata16,
        input  pdata24, pvalid24, perr24, pdata16, pvalid16, perr16, wcnt24, wcnt16
    );

    modport slave (
        input  bit_en24, sync24, sdata24, bit_en16, sync16, sdata16,
        output pdata24, pvalid24, perr24, pdata16, pvalid16, perr16, wcnt24, wcnt16
    );
endinterface

// File: rtl/test_s2p.sv
// Dual-channel serial-to-parallel receiver: MSB-first words framed by a sync
// strobe, paced by a bit-enable, delivered as registered words with pulses.
module test_s2p_chan #(
    parameter int W     = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sync,
    input  logic             sdata,
    output logic [W-1:0]     pdata,
    output logic             pvalid,
    output logic             perr,
    output logic [CNT_W-1:0] wcnt
);
    localparam int BCW = $clog2(W + 1);
    localparam logic [BCW-1:0] LAST = BCW'(W);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r,  state_s;
    logic [W-1:0]     shreg_r,  shreg_s;
    logic [BCW-1:0]   cnt_r,    cnt_s;
    logic [W-1:0]     pdata_r,  pdata_s;
    logic             pvalid_r, pvalid_s;
    logic             perr_r,   perr_s;
    logic [CNT_W-1:0] wcnt_r,   wcnt_s;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            shreg_r  <= {W{1'b0}};
            cnt_r    <= {BCW{1'b0}};
            pdata_r  <= {W{1'b0}};
            pvalid_r <= 1'b0;
            perr_r   <= 1'b0;
            wcnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            pdata_r  <= pdata_s;
            pvalid_r <= pvalid_s;
            perr_r   <= perr_s;
            wcnt_r   <= wcnt_s;
        end
    end

    // Next-state: framing, shifting, word delivery and resync handling
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        pdata_s  = pdata_r;
        pvalid_s = 1'b0;
        perr_s   = 1'b0;
        wcnt_s   = wcnt_r;
        case (state_r)
            IDLE: begin
                if (bit_en && sync) begin
                    shreg_s = {{(W-1){1'b0}}, sdata};
                    cnt_s   = BCW'(1);
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST) begin
                    // Word complete: deliver it; a sync this cycle starts the next word cleanly
                    pdata_s  = shreg_r;
                    pvalid_s = 1'b1;
                    if (wcnt_r != {CNT_W{1'b1}}) begin
                        wcnt_s = wcnt_r + CNT_W'(1);
                    end else begin
                        wcnt_s = wcnt_r;
                    end
                    if (bit_en && sync) begin
                        shreg_s = {{(W-1){1'b0}}, sdata};
                        cnt_s   = BCW'(1);
                        state_s = SHIFT;
                    end else begin
                        cnt_s   = {BCW{1'b0}};
                        state_s = IDLE;
                    end
                end else if (bit_en) begin
                    if (sync) begin
                        perr_s  = 1'b1;
                        shreg_s = {{(W-1){1'b0}}, sdata};
                        cnt_s   = BCW'(1);
                    end else begin
                        shreg_s = {shreg_r[W-2:0], sdata};
                        cnt_s   = cnt_r + BCW'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {BCW{1'b0}};
            end
        endcase
    end

    assign pdata  = pdata_r;
    assign pvalid = pvalid_r;
    assign perr   = perr_r;
    assign wcnt   = wcnt_r;
endmodule

module test_s2p #(
    parameter int WIDTH24 = 24,
    parameter int WIDTH16 = 16,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    test_s2p_if.slave  bus
);
    test_s2p_chan #(.W(WIDTH24), .CNT_W(CNT_W)) u_ch24 (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bus.bit_en24),
        .sync   (bus.sync24),
        .sdata  (bus.sdata24),
        .pdata  (bus.pdata24),
        .pvalid (bus.pvalid24),
        .perr   (bus.perr24),
        .wcnt   (bus.wcnt24)
    );

    test_s2p_chan #(.W(WIDTH16), .CNT_W(CNT_W)) u_ch16 (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bus.bit_en16),
        .sync   (bus.sync16),
        .sdata  (bus.sdata16),
        .pdata  (bus.pdata16),
        .pvalid (bus.pvalid16),
        .perr   (bus.perr16),
        .wcnt   (bus.wcnt16)
    );
endmodule
